piso_tx_arbiter: RTL and testbench
==================================

Name: piso_tx_arbiter

Overview:
- Two-requester controller that shares one parallel-in/serial-out shifter between two parallel word sources.
- Accepts words through per-requester valid/ready handshakes, arbitrates round-robin, loads the shifter, and sequences WIDTH shift cycles MSB-first.
- Emits a frame qualifier and an end-of-word pulse on the serial side, then enforces an inter-frame gap.
- Sits between word-producing logic and a serial link or pin driver.

Parameters:
- WIDTH, 4, word width in bits (>=2).
- GAP, 1, idle cycles inserted after each word's last bit before the next handshake can occur (>=0).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word; must be held stable while req0_valid=1 and req0_ready=0.
- req0_ready  output  1  controller accepts req0_data this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word; same stability rule as req0_data.
- req1_ready  output  1  controller accepts req1_data this cycle.
- sout  output  1  serial data, MSB first; 0 outside frames.
- sframe  output  1  high in every cycle in which sout carries a valid bit.
- sdone  output  1  one-cycle pulse coincident with the last bit of a word.
- grant_id  output  1  source of the word currently being shifted; holds its value after a frame ends.
- busy  output  1  high in SHIFT and GAP states.

Behaviour:
- Reset (async, reset=0): state=IDLE; shifter, bit counter and gap counter are 0. Outputs: sout=0, sframe=0, sdone=0, busy=0, grant_id=0, both readys=0. last_grant=1, so req0 wins the first contention.
- States:
  - IDLE: readys are combinational. req0_ready=req0_valid & (~req1_valid | last_grant==1); req1_ready=req1_valid & (~req0_valid | last_grant==0). At most one ready is high.
  - A transfer is valid & ready at a rising edge. On a transfer: load the shifter with the winning data, set grant_id and last_grant to the winner, set bitcnt=WIDTH-1, go to SHIFT.
  - SHIFT: sframe=1; sout=shifter MSB. Each cycle the shifter shifts left with 0 fill and bitcnt decrements. sdone=1 when bitcnt==0. From bitcnt==0, go to GAP if GAP>0, otherwise to IDLE.
  - GAP: sframe=0, sout=0. Stays for exactly GAP cycles, then goes to IDLE.
- Timing: with the handshake at edge E, bits appear in the WIDTH cycles after E. The next handshake is possible no earlier than GAP+1 cycles after the last bit (the IDLE cycle counts as one). Peak throughput is one word per WIDTH+GAP+1 cycles.
- Readys are 0 in SHIFT and GAP, whatever the valids are.
- A requester dropping valid without a handshake is legal; the word is simply not sent.
- Both valids rising in the same cycle: the requester not equal to last_grant wins. If only one is valid, it wins regardless of last_grant.
- Reset asserted mid-frame: the frame is aborted immediately. sframe, sout and busy drop asynchronously, and no sdone is issued.
- Counter widths: bitcnt uses $clog2(WIDTH) bits; the gap counter uses $clog2(GAP+1) bits (minimum 1).

Decomposition:
- Package piso_tx_pkg holds:
  - state enum {ST_IDLE, ST_SHIFT, ST_GAP};
  - requester index constants REQ0=1'b0, REQ1=1'b1.
- Sub-module piso_shifter:
  - WIDTH-parameterised register with inputs load and shift_en, async active-low reset, MSB serial output, 0 fill;
  - load has priority over shift_en.
- The controller instantiates one piso_shifter. It owns the FSM, the arbiter and the counters.

Test Plan (WIDTH=4, GAP=1 unless stated):
- Reset/single word:
  - Hold reset=0 → all outputs 0.
  - Release; req0_valid=1, req0_data=4'b1010 → req0_ready=1 that cycle.
  - Next 4 cycles: sout=1,0,1,0, sframe=1, grant_id=0, sdone on the 4th.
  - Then 1 GAP cycle with busy=1, then IDLE with busy=0.
- Contention after reset: req0=4'b1100 and req1=4'b0011 both valid → req0 is served first (1,1,0,0).
  - req1_ready stays 0 through SHIFT and GAP.
  - Then req1 is served (0,0,1,1) with grant_id=1.
- Fairness: both valids held high continuously for 6 words → grant_id alternates 0,1,0,1,0,1. Each frame starts exactly 6 cycles after the previous one.
- Mid-frame reset: req1=4'b1111 accepted; reset=0 during the 2nd bit → sframe, sout and busy are 0 immediately, with no sdone.
  - After release, both valid → req0 wins.
- Parameter sweep:
  - GAP=0: back-to-back req0 words → sframe low for exactly 1 cycle between frames.
  - WIDTH=8: 8'hA5 → serial 1,0,1,0,0,1,0,1 with sdone on bit 8.
- Idle stability: valids low for 20 cycles → readys, sframe, sdone and busy stay 0. A valid pulsed for 1 cycle with no handshake sends nothing.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the two-requester serial transmitter.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out register: MSB out, zero fill, load beats shift.
module piso_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  // Load a new word or shift left one bit per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        q <= '0;
    else if (load)     q <= din;
    else if (shift_en) q <= {q[WIDTH-2:0], 1'b0};
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter feeding one shared PISO shifter, with frame
// qualifier, end-of-word pulse and a fixed inter-frame gap.
module piso_tx_arbiter
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sframe,
  output logic             sdone,
  output logic             grant_id,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t           state, state_nxt;
  logic [BW-1:0]    bitcnt;
  logic [GW-1:0]    gapcnt;
  logic             last_grant;
  logic             load, shift_en, win, msb;
  logic [WIDTH-1:0] load_data;

  assign win       = req1_ready;
  assign load_data = (win == REQ1) ? req1_data : req0_data;
  // Serial outputs are decoded from state so an async reset kills them at once.
  assign sout      = sframe & msb;
  assign busy      = (state != ST_IDLE);

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .din      (load_data),
    .msb      (msb)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Grant history, bit counter and gap counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_id   <= REQ0;
      last_grant <= REQ1;
      bitcnt     <= '0;
      gapcnt     <= '0;
    end else begin
      if (load) begin
        grant_id   <= win;
        last_grant <= win;
        bitcnt     <= BW'(WIDTH - 1);
      end else if (shift_en) begin
        bitcnt <= bitcnt - 1'b1;
      end
      if (state == ST_SHIFT && state_nxt == ST_GAP) gapcnt <= GW'(GAP - 1);
      else if (state == ST_GAP)                     gapcnt <= gapcnt - 1'b1;
    end
  end

  // Arbitration, next state and frame outputs.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    sframe     = 1'b0;
    sdone      = 1'b0;
    case (state)
      ST_IDLE: begin
        // Contention goes to whoever was not served last.
        req0_ready = reset & req0_valid & (~req1_valid | (last_grant == REQ1));
        req1_ready = reset & req1_valid & (~req0_valid | (last_grant == REQ0));
        if (req0_ready | req1_ready) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sframe   = 1'b1;
        shift_en = 1'b1;
        if (bitcnt == '0) begin
          sdone     = 1'b1;
          state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gapcnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench: directed scenarios plus random traffic against a timeline model.
module tb_piso_tx_arbiter;

  localparam int W = 4;
  localparam int G = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // main DUT (WIDTH=4, GAP=1)
  logic v0 = 0, v1 = 0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic r0, r1, sout, sframe, sdone, gid, busy;

  // sweep DUTs
  logic g0_v0 = 0;
  logic [3:0] g0_d0 = '0;
  logic g0_r0, g0_r1, g0_sout, g0_sframe, g0_sdone, g0_gid, g0_busy;
  logic w8_v0 = 0;
  logic [7:0] w8_d0 = '0;
  logic w8_r0, w8_r1, w8_sout, w8_sframe, w8_sdone, w8_gid, w8_busy;

  piso_tx_arbiter #(.WIDTH(W), .GAP(G)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .sout(sout), .sframe(sframe), .sdone(sdone), .grant_id(gid), .busy(busy)
  );

  piso_tx_arbiter #(.WIDTH(4), .GAP(0)) dut_g0 (
    .clk(clk), .reset(reset),
    .req0_valid(g0_v0), .req0_data(g0_d0), .req0_ready(g0_r0),
    .req1_valid(1'b0), .req1_data(4'h0), .req1_ready(g0_r1),
    .sout(g0_sout), .sframe(g0_sframe), .sdone(g0_sdone), .grant_id(g0_gid), .busy(g0_busy)
  );

  piso_tx_arbiter #(.WIDTH(8), .GAP(1)) dut_w8 (
    .clk(clk), .reset(reset),
    .req0_valid(w8_v0), .req0_data(w8_d0), .req0_ready(w8_r0),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(w8_r1),
    .sout(w8_sout), .sframe(w8_sframe), .sdone(w8_sdone), .grant_id(w8_gid), .busy(w8_busy)
  );

  // Model: a timeline of expected per-cycle serial-side outputs.
  typedef struct packed { logic sf; logic so; logic sd; logic bs; } ent_t;
  ent_t tl[$];
  logic m_last = 1'b1;
  logic m_grant = 1'b0;
  logic acc0 = 0, acc1 = 0;
  logic prev_sf = 0;
  int   checks = 0, errors = 0, cyc = 0;
  int   starts[$];
  logic gids[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: compare mid-cycle, then advance the model at the edge.
  task automatic step();
    ent_t e;
    logic er0, er1;
    logic [W-1:0] d;
    @(negedge clk);
    e   = (tl.size() > 0) ? tl[0] : '0;
    er0 = (tl.size() == 0) && v0 && (!v1 || m_last);
    er1 = (tl.size() == 0) && v1 && (!v0 || !m_last);
    chk("req0_ready", r0, er0);
    chk("req1_ready", r1, er1);
    chk("sframe", sframe, e.sf);
    chk("sout", sout, e.so);
    chk("sdone", sdone, e.sd);
    chk("busy", busy, e.bs);
    chk("grant_id", gid, m_grant);
    if (sframe && !prev_sf) begin
      starts.push_back(cyc);
      gids.push_back(gid);
    end
    prev_sf = sframe;
    @(posedge clk);
    cyc++;
    acc0 = 0;
    acc1 = 0;
    if (tl.size() > 0) begin
      void'(tl.pop_front());
    end else if (er0 || er1) begin
      d = er1 ? d1 : d0;
      m_grant = er1;
      m_last  = er1;
      acc0 = er0;
      acc1 = er1;
      for (int i = W - 1; i >= 0; i--) tl.push_back('{1'b1, d[i], (i == 0), 1'b1});
      for (int i = 0; i < G; i++) tl.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    end
    #1;
  endtask

  // Assert reset now, check outputs drop at once, release after an edge.
  task automatic do_reset();
    reset = 1'b0;
    tl.delete();
    m_last  = 1'b1;
    m_grant = 1'b0;
    #1;
    chk("rst_sframe", sframe, 1'b0);
    chk("rst_sout", sout, 1'b0);
    chk("rst_sdone", sdone, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", gid, 1'b0);
    chk("rst_ready0", r0, 1'b0);
    chk("rst_ready1", r1, 1'b0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    prev_sf = 1'b0;
  endtask

  initial begin
    logic [8:0] sf_pat, so_pat, sd_pat;
    logic [7:0] w8_pat;

    @(posedge clk);
    #1;
    do_reset();

    // single word from req0
    v0 = 1; d0 = 4'b1010;
    step();
    v0 = 0;
    repeat (6) step();

    // contention right after reset: req0 first, then req1
    do_reset();
    v0 = 1; d0 = 4'b1100; v1 = 1; d1 = 4'b0011;
    step();
    v0 = 0;
    repeat (6) step();
    v1 = 0;
    repeat (6) step();

    // fairness with both valids held
    starts.delete();
    gids.delete();
    v0 = 1; d0 = 4'b0110; v1 = 1; d1 = 4'b1001;
    repeat (36) step();
    v0 = 0; v1 = 0;
    repeat (6) step();
    chk_int("fair_nframes", gids.size(), 6);
    for (int i = 0; i < gids.size(); i++) chk("fair_grant", gids[i], 1'(i % 2));
    for (int i = 1; i < starts.size(); i++) chk_int("fair_spacing", starts[i] - starts[i-1], 6);

    // reset in the middle of a frame
    v1 = 1; d1 = 4'b1111;
    step();
    v1 = 0;
    step();
    do_reset();
    v0 = 1; v1 = 1; d0 = 4'b0001; d1 = 4'b1000;
    step();
    v0 = 0; v1 = 0;
    repeat (6) step();

    // idle stability, then a one-cycle valid pulse while busy
    repeat (20) step();
    v0 = 1; d0 = 4'b0101;
    step();
    v0 = 0;
    step();
    v1 = 1; d1 = 4'b1111;
    step();
    v1 = 0;
    repeat (8) step();

    // random traffic honouring the hold-while-waiting rule
    for (int k = 0; k < 400; k++) begin
      if (v0 && !acc0) begin
        if ($urandom_range(0, 7) == 0) v0 = 0;
      end else begin
        v0 = 1'($urandom_range(0, 1));
        d0 = 4'($urandom);
      end
      if (v1 && !acc1) begin
        if ($urandom_range(0, 7) == 0) v1 = 0;
      end else begin
        v1 = 1'($urandom_range(0, 1));
        d1 = 4'($urandom);
      end
      step();
    end
    v0 = 0; v1 = 0;
    repeat (8) step();

    // GAP=0: back-to-back words, one idle cycle between frames
    sf_pat = 9'b111101111;
    so_pat = 9'b100101001;
    sd_pat = 9'b000100001;
    g0_v0 = 1; g0_d0 = 4'b1001;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("g0_sframe", g0_sframe, sf_pat[8-i]);
      chk("g0_sout", g0_sout, so_pat[8-i]);
      chk("g0_sdone", g0_sdone, sd_pat[8-i]);
    end
    g0_v0 = 0;
    repeat (6) @(posedge clk);
    #1;

    // WIDTH=8 word
    w8_pat = 8'hA5;
    w8_v0 = 1; w8_d0 = 8'hA5;
    @(posedge clk);
    #1;
    w8_v0 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("w8_sout", w8_sout, w8_pat[7-i]);
      chk("w8_sframe", w8_sframe, 1'b1);
      chk("w8_sdone", w8_sdone, (i == 7));
    end
    @(negedge clk);
    chk("w8_gap_sframe", w8_sframe, 1'b0);
    chk("w8_gap_busy", w8_busy, 1'b1);
    @(negedge clk);
    chk("w8_idle_busy", w8_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
